// File: rtl/argmax_classifier.sv
// argmax_classifier: scans the logits RAM after the last layer and reports index/value of the largest logit.
// Define ARGMAX_RUNNER_UP_EN to also track the runner-up logit and the top-two margin.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int RD_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_CLASSES)-1:0] logits_rdaddr,
  input  logic [DATA_WIDTH-1:0]          logits_q,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic [DATA_WIDTH-1:0]          class_val
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [$clog2(NUM_CLASSES)-1:0] second_idx,
  output logic [DATA_WIDTH-1:0]          second_val,
  output logic [DATA_WIDTH:0]            margin
`endif
);

  localparam int AW = $clog2(NUM_CLASSES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CLASSES - 1);

  if (NUM_CLASSES < 2 || (RD_LATENCY != 1 && RD_LATENCY != 2) || FRAC_BITS >= DATA_WIDTH) begin : g_bad_params
    $error("argmax_classifier: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         rd_cnt;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [AW-1:0]         tag_pipe [RD_LATENCY];
  logic                  smp_vld, smp_last;
  logic [AW-1:0]         smp_idx;
  logic [AW-1:0]         max_idx, max_idx_nxt;
  logic [DATA_WIDTH-1:0] max_val, max_val_nxt;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [AW-1:0]         sec_idx, sec_idx_nxt;
  logic [DATA_WIDTH-1:0] sec_val, sec_val_nxt;
`endif

  assign smp_vld  = vld_pipe[RD_LATENCY-1];
  assign smp_idx  = tag_pipe[RD_LATENCY-1];
  assign smp_last = smp_vld && (smp_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    done          = 1'b0;
    logits_rdaddr = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        logits_rdaddr = rd_cnt;
        if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (smp_last) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid/tag pipeline mirrors the RAM latency so each returning word carries its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      rd_cnt <= (state == ISSUE) ? rd_cnt + AW'(1) : '0;
      if (state == IDLE && start) begin
        vld_pipe <= '0;
        for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
      end else begin
        vld_pipe[0] <= (state == ISSUE);
        tag_pipe[0] <= rd_cnt;
        for (int i = 1; i < RD_LATENCY; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          tag_pipe[i] <= tag_pipe[i-1];
        end
      end
    end
  end

`ifdef ARGMAX_RUNNER_UP_EN
  always_comb begin
    max_idx_nxt = max_idx;
    max_val_nxt = max_val;
    sec_idx_nxt = sec_idx;
    sec_val_nxt = sec_val;
    if (smp_vld) begin
      if (smp_idx == '0) begin
        max_idx_nxt = smp_idx;
        max_val_nxt = logits_q;
      end else if ($signed(logits_q) > $signed(max_val)) begin
        sec_idx_nxt = max_idx;
        sec_val_nxt = max_val;
        max_idx_nxt = smp_idx;
        max_val_nxt = logits_q;
      end else if (smp_idx == AW'(1) || $signed(logits_q) > $signed(sec_val)) begin
        sec_idx_nxt = smp_idx;
        sec_val_nxt = logits_q;
      end
    end
  end
`else
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    max_idx_nxt = max_idx;
    max_val_nxt = max_val;
    if (smp_vld) begin
      if (smp_idx == '0 || $signed(logits_q) > $signed(max_val)) begin
        max_idx_nxt = smp_idx;
        max_val_nxt = logits_q;
      end
    end
  end
`endif

  // Results load on the edge into FINISH so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx   <= '0;
      max_val   <= '0;
      class_idx <= '0;
      class_val <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      sec_idx    <= '0;
      sec_val    <= '0;
      second_idx <= '0;
      second_val <= '0;
      margin     <= '0;
`endif
    end else begin
      max_idx <= max_idx_nxt;
      max_val <= max_val_nxt;
`ifdef ARGMAX_RUNNER_UP_EN
      sec_idx <= sec_idx_nxt;
      sec_val <= sec_val_nxt;
`endif
      if (state == DRAIN && smp_last) begin
        class_idx <= max_idx_nxt;
        class_val <= max_val_nxt;
`ifdef ARGMAX_RUNNER_UP_EN
        second_idx <= sec_idx_nxt;
        second_val <= sec_val_nxt;
        margin     <= {max_val_nxt[DATA_WIDTH-1], max_val_nxt} - {sec_val_nxt[DATA_WIDTH-1], sec_val_nxt};
`endif
      end
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed checks of argmax_classifier at RD_LATENCY 1 and 2 against behavioural RAMs.
// Runner-up checks are included when ARGMAX_RUNNER_UP_EN is defined.
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start1 = 1'b0;
  logic          start2 = 1'b0;
  logic          busy1, done1, busy2, done2;
  logic [AW-1:0] addr1, addr2, idx1, idx2;
  logic [DW-1:0] q1, q2, q2a, val1, val2;
  logic [DW-1:0] mem [16];
  int            vectors = 0;
  int            miscompares = 0;
  int            done_cyc;
  int            done_seen;
  logic          busy_c1;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [AW-1:0] sidx1, sidx2;
  logic [DW-1:0] sval1, sval2;
  logic [DW:0]   marg1, marg2;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) q1 <= mem[addr1];
  always @(posedge clk) begin
    q2a <= mem[addr2];
    q2  <= q2a;
  end

  argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .FRAC_BITS(8), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .logits_rdaddr(addr1), .logits_q(q1), .class_idx(idx1), .class_val(val1)
`ifdef ARGMAX_RUNNER_UP_EN
    , .second_idx(sidx1), .second_val(sval1), .margin(marg1)
`endif
  );

  argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .FRAC_BITS(8), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .logits_rdaddr(addr2), .logits_q(q2), .class_idx(idx2), .class_val(val2)
`ifdef ARGMAX_RUNNER_UP_EN
    , .second_idx(sidx2), .second_val(sval2), .margin(marg2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle (cycle 0), optionally again at cycle again_cyc, and reports the done cycle (0 = timeout).
  task automatic applyStimulus(input bit use_l2, input int again_cyc, output int dcyc, output logic b1);
    dcyc = 0;
    b1   = 1'b0;
    @(negedge clk);
    if (use_l2) start2 = 1'b1; else start1 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      if (cyc == again_cyc) begin
        if (use_l2) start2 = 1'b1; else start1 = 1'b1;
      end
      if (cyc == 1) b1 = use_l2 ? busy2 : busy1;
      if (use_l2 ? done2 : done1) begin
        dcyc = cyc;
        break;
      end
    end
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy1), 32'h0);
    checkOutput("rst_done", 32'(done1), 32'h0);
    checkOutput("rst_rdaddr", 32'(addr1), 32'h0);
    checkOutput("rst_class_idx", 32'(idx1), 32'h0);
    checkOutput("rst_class_val", 32'(val1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) mem[k] = DW'(16 * k);
    applyStimulus(1'b0, 0, done_cyc, busy_c1);
    checkOutput("asc_done_cycle", 32'(done_cyc), 32'd12);
    checkOutput("asc_busy_cycle1", 32'(busy_c1), 32'h1);
    checkOutput("asc_class_idx", 32'(idx1), 32'd9);
    checkOutput("asc_class_val", 32'(val1), 32'h0090);
    @(negedge clk);
    checkOutput("asc_done_pulse", 32'(done1), 32'h0);
    checkOutput("asc_busy_after", 32'(busy1), 32'h0);
    checkOutput("asc_idx_hold", 32'(idx1), 32'd9);

    for (int k = 0; k < N; k++) mem[k] = 16'h0100;
    applyStimulus(1'b0, 0, done_cyc, busy_c1);
    checkOutput("tie_done_cycle", 32'(done_cyc), 32'd12);
    checkOutput("tie_class_idx", 32'(idx1), 32'd0);
    checkOutput("tie_class_val", 32'(val1), 32'h0100);

    for (int k = 0; k < N; k++) mem[k] = 16'hFE00;
    mem[4] = 16'hFF80;
    applyStimulus(1'b0, 0, done_cyc, busy_c1);
    checkOutput("neg_class_idx", 32'(idx1), 32'd4);
    checkOutput("neg_class_val", 32'(val1), 32'hFF80);

    for (int k = 0; k < N; k++) mem[k] = 16'h0100;
    mem[0] = 16'h8000;
    mem[1] = 16'hFFFF;
    mem[2] = 16'h7000;
    mem[9] = 16'h7FFF;
    applyStimulus(1'b1, 5, done_cyc, busy_c1);
    checkOutput("lat2_done_cycle", 32'(done_cyc), 32'd13);
    checkOutput("lat2_class_idx", 32'(idx2), 32'd9);
    checkOutput("lat2_class_val", 32'(val2), 32'h7FFF);
    repeat (2) @(negedge clk);
    checkOutput("lat2_no_requeue_busy", 32'(busy2), 32'h0);
    checkOutput("lat2_idle_rdaddr", 32'(addr2), 32'h0);

    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy1), 32'h0);
    checkOutput("abort_done", 32'(done1), 32'h0);
    checkOutput("abort_rdaddr", 32'(addr1), 32'h0);
    checkOutput("abort_class_idx", 32'(idx1), 32'h0);
    checkOutput("abort_class_val", 32'(val1), 32'h0);
    checkOutput("abort_lat2_class_idx", 32'(idx2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done1) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'h0);

    for (int k = 0; k < N; k++) mem[k] = 16'h0010;
    mem[6] = 16'h0050;
    applyStimulus(1'b0, 0, done_cyc, busy_c1);
    checkOutput("post_done_cycle", 32'(done_cyc), 32'd12);
    checkOutput("post_class_idx", 32'(idx1), 32'd6);
    checkOutput("post_class_val", 32'(val1), 32'h0050);

`ifdef ARGMAX_RUNNER_UP_EN
    for (int k = 0; k < N; k++) mem[k] = 16'h0000;
    mem[2] = 16'h0300;
    mem[5] = 16'h0280;
    applyStimulus(1'b0, 0, done_cyc, busy_c1);
    checkOutput("ru_done_cycle", 32'(done_cyc), 32'd12);
    checkOutput("ru_class_idx", 32'(idx1), 32'd2);
    checkOutput("ru_second_idx", 32'(sidx1), 32'd5);
    checkOutput("ru_second_val", 32'(sval1), 32'h0280);
    checkOutput("ru_margin", 32'(marg1), 32'h0080);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Final classification stage of the MLP pipeline: once the last `layer` instance has written its logits into the output RAM, this block scans that RAM and reports the index and value of the largest logit. It sits directly downstream of the last layer, on the read port of the logits RAM. It drives the predicted class and a done pulse to the top-level controller.

## Interface
- `NUM_CLASSES`, 10: number of logits to scan; must be ≥ 2.
- `DATA_WIDTH`, 16: logit width, signed two's complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- `FRAC_BITS`, 8: fractional bits; affects only documentation of values, not compare logic.
- `RD_LATENCY`, 1: logits RAM read latency in cycles; legal values 1 or 2.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until the done cycle, inclusive.
- `done` out 1: one-cycle pulse when results are valid.
- `logits_rdaddr` out clog2(NUM_CLASSES): RAM read address.
- `logits_q` in DATA_WIDTH: RAM read data, valid RD_LATENCY cycles after address.
- `class_idx` out clog2(NUM_CLASSES): index of maximum logit.
- `class_val` out DATA_WIDTH: value of maximum logit (signed).
- `second_idx`, `second_val`, `margin` out clog2(NUM_CLASSES), DATA_WIDTH, DATA_WIDTH+1: present only with ARGMAX_RUNNER_UP_EN.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: `start`=1 → ISSUE; clear read counter and valid pipeline.
- ISSUE: drive `logits_rdaddr` = counter, counter +1 per cycle; after issuing address NUM_CLASSES-1 → DRAIN.
- DRAIN: wait until the last read's data has been consumed (RD_LATENCY cycles) → FINISH.
- FINISH: assert `done` one cycle, update outputs → IDLE.
- A valid shift register of depth RD_LATENCY tags returning data with its index; compare unit is fed only on tagged-valid cycles.
- First valid sample (index 0) loads the running max unconditionally.
- Subsequent sample replaces the max only if strictly greater (signed compare): ties keep the lowest index.
- Results register separately from running max; `class_idx`/`class_val` change only in FINISH and hold until the next FINISH.
- `start` while busy is ignored; no queuing.
- `logits_rdaddr` holds 0 outside ISSUE.
- Reset (any state, mid-scan included): FSM → IDLE, valid pipeline cleared, all outputs 0; no `done` for the aborted scan.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..NUM_CLASSES: ISSUE, address k driven in cycle k+1.
- Data for address k sampled in cycle k+1+RD_LATENCY.
- `done` high in cycle NUM_CLASSES+RD_LATENCY+1; total scan = NUM_CLASSES+RD_LATENCY+2 cycles incl. start cycle (13 for defaults).
- New `start` accepted in the cycle after `done` (IDLE).
- Reset values: `busy`=0, `done`=0, `logits_rdaddr`=0, `class_idx`=0, `class_val`=0, runner-up outputs 0.

## Configuration
- `ARGMAX_RUNNER_UP_EN` defined: block also tracks the second-largest logit. On a new max, old max moves to runner-up; otherwise a sample strictly greater than runner-up (or the first sample at index 1 when not the new max) replaces it; ties keep lowest index. `margin` = class_val − second_val, sign-extended to DATA_WIDTH+1, always ≥ 0. Ports exist and update in FINISH.
- Not defined: runner-up ports and logic absent; behaviour otherwise identical.

## Test plan
- Logits 0..9 = 0x0010·k (ascending) → `class_idx`=9, `class_val`=0x0090, `done` at cycle 12 (RD_LATENCY=1).
- Logits all 0x0100 except index 3 = 0x0100 and index 7 = 0x0100 (full tie) → `class_idx`=0 (lowest index wins).
- All negative: index 4 = 0xFF80 (−0.5), others 0xFE00 → `class_idx`=4, `class_val`=0xFF80 (signed compare, not unsigned).
- RD_LATENCY=2, max at index 9 = 0x7FFF → `class_idx`=9, `done` at cycle 13; second `start` pulsed at cycle 5 ignored.
- `rst_n` low at cycle 6 of a scan → all outputs 0, no `done`; next scan completes normally with correct result.
- With ARGMAX_RUNNER_UP_EN, logits idx2=0x0300, idx5=0x0280, rest 0 → `class_idx`=2, `second_idx`=5, `margin`=0x0080.
